// File: rtl/config_memory_arbiter.sv
// config_memory_arbiter
// Two-port round-robin arbiter in front of a single-port memory with a fixed
// read latency. Only one transaction is in flight at a time. Port A may claim
// exclusive access (a_lock) across consecutive transactions.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   a_*/b_* req/we/addr/wdata  requester command, held until the matching ack
//   a_lock                  port A exclusive-access request
//   a_ack/b_ack             one-cycle completion pulse
//   a_rdata/b_rdata         read data, updated only by a read on that port
//   mem_en/mem_we/mem_addr/mem_din/mem_dout  memory interface
//   busy                    high whenever the FSM is not IDLE
module config_memory_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  a_lock,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Cycles spent in WAIT; a latency-1 memory skips WAIT entirely.
  localparam logic [2:0] WAIT_CYCLES      = 3'(READ_LATENCY - 32'sd1);
  localparam bit         SINGLE_CYCLE_RD  = (READ_LATENCY == 32'sd1);

  state_t          state_r;
  logic            grant_b_r;   // current transaction belongs to port B
  logic            last_b_r;    // most recent grant went to B
  logic            lock_r;      // A finished a transaction while holding a_lock
  logic            cmd_we_r;
  logic [2:0]      wait_cnt_r;

  logic                  lock_hold_s;
  logic                  b_eligible_s;
  logic                  any_eligible_s;
  logic                  pick_b_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;

  // The lock only bites while A keeps a_lock high; dropping it in IDLE
  // releases B in that same cycle.
  assign lock_hold_s    = lock_r & a_lock;
  assign b_eligible_s   = b_req & ~lock_hold_s;
  assign any_eligible_s = a_req | b_eligible_s;
  // On a tie the port that did not win last time gets the grant.
  assign pick_b_s       = b_eligible_s & (~a_req | ~last_b_r);
  assign sel_we_s       = pick_b_s ? b_we    : a_we;
  assign sel_addr_s     = pick_b_s ? b_addr  : a_addr;
  assign sel_wdata_s    = pick_b_s ? b_wdata : a_wdata;

  // Arbiter FSM: grant and command capture, memory strobe, read capture, acks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      grant_b_r  <= 1'b0;
      last_b_r   <= 1'b1;
      lock_r     <= 1'b0;
      cmd_we_r   <= 1'b0;
      wait_cnt_r <= 3'd0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      busy       <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!a_lock) begin
            lock_r <= 1'b0;
          end
          if (any_eligible_s) begin
            grant_b_r <= pick_b_s;
            last_b_r  <= pick_b_s;
            cmd_we_r  <= sel_we_s;
            mem_en    <= 1'b1;
            mem_we    <= sel_we_s;
            mem_addr  <= sel_addr_s;
            mem_din   <= sel_wdata_s;
            busy      <= 1'b1;
            state_r   <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (cmd_we_r) begin
            a_ack   <= ~grant_b_r;
            b_ack   <= grant_b_r;
            state_r <= DONE;
          end else if (SINGLE_CYCLE_RD) begin
            if (grant_b_r) begin
              b_rdata <= mem_dout;
            end else begin
              a_rdata <= mem_dout;
            end
            a_ack   <= ~grant_b_r;
            b_ack   <= grant_b_r;
            state_r <= DONE;
          end else begin
            wait_cnt_r <= WAIT_CYCLES;
            state_r    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt_r <= 3'd1) begin
            if (grant_b_r) begin
              b_rdata <= mem_dout;
            end else begin
              a_rdata <= mem_dout;
            end
            a_ack   <= ~grant_b_r;
            b_ack   <= grant_b_r;
            state_r <= DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r - 3'd1;
          end
        end
        DONE: begin
          // a_lock is only meaningful at the end of an A transaction.
          if (!grant_b_r) begin
            lock_r <= a_lock;
          end
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_memory_arbiter.sv
// Bench for config_memory_arbiter: three instances (READ_LATENCY 2, 1, 7),
// each with its own behavioural memory. Instance 0 is exercised with directed
// and random transactions against a transaction-level reference model;
// instances 1 and 2 check read latency and data for the extreme builds.
module tb_config_memory_arbiter;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int RL0 = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  logic          a_req   [3];
  logic          a_we    [3];
  logic [AW-1:0] a_addr  [3];
  logic [DW-1:0] a_wdata [3];
  logic          a_lock  [3];
  logic          b_req   [3];
  logic          b_we    [3];
  logic [AW-1:0] b_addr  [3];
  logic [DW-1:0] b_wdata [3];

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state (instance 0)
  logic [DW-1:0] ref_mem [1024];
  bit            ref_last_b;
  bit            ref_lock;
  logic [DW-1:0] exp_a_rd;
  logic [DW-1:0] exp_b_rd;
  bit            got_b;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    return 32'h5A00_0000 ^ ({22'd0, a} * 32'h0001_0101);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RL = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
    logic          a_ack, b_ack, mem_en, mem_we, busy;
    logic [DW-1:0] a_rdata, b_rdata, mem_din, mem_dout;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem [1024];
    bit            written [1024];
    logic [AW-1:0] rd_addr;
    bit            rd_live;
    int            since;

    config_memory_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req[g]), .a_we(a_we[g]), .a_addr(a_addr[g]), .a_wdata(a_wdata[g]),
      .a_lock(a_lock[g]),
      .b_req(b_req[g]), .b_we(b_we[g]), .b_addr(b_addr[g]), .b_wdata(b_wdata[g]),
      .a_ack(a_ack), .a_rdata(a_rdata), .b_ack(b_ack), .b_rdata(b_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .busy(busy)
    );

    // Memory: a read strobed with mem_en delivers data READ_LATENCY clock edges
    // later (the edge closing the mem_en cycle counts as the first); before
    // that the output carries a poison word.
    always @(posedge clk) begin
      if (mem_en && mem_we) begin
        mem[mem_addr]     <= mem_din;
        written[mem_addr] <= 1'b1;
      end
      if (mem_en && !mem_we) begin
        rd_addr <= mem_addr;
        rd_live <= 1'b1;
        since   <= 1;
      end else if (rd_live && since < 8) begin
        since <= since + 1;
      end
    end

    always_comb begin
      mem_dout = 32'hDEAD_BEEF;
      if (mem_en) begin
        if (RL == 1 && !mem_we)
          mem_dout = written[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
      end else if (rd_live && since >= RL - 1) begin
        mem_dout = written[rd_addr] ? mem[rd_addr] : init_word(rd_addr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_ack"},    32'(g_dut[0].a_ack),    32'd0);
    check({tag, "_b_ack"},    32'(g_dut[0].b_ack),    32'd0);
    check({tag, "_a_rdata"},  g_dut[0].a_rdata,       32'd0);
    check({tag, "_b_rdata"},  g_dut[0].b_rdata,       32'd0);
    check({tag, "_mem_en"},   32'(g_dut[0].mem_en),   32'd0);
    check({tag, "_mem_we"},   32'(g_dut[0].mem_we),   32'd0);
    check({tag, "_mem_addr"}, 32'(g_dut[0].mem_addr), 32'd0);
    check({tag, "_mem_din"},  g_dut[0].mem_din,       32'd0);
    check({tag, "_busy"},     32'(g_dut[0].busy),     32'd0);
  endtask

  // One transaction on instance 0, starting in an IDLE cycle with the
  // requests already driven. The model picks the winner from the eligibility
  // and round-robin rules, then predicts latency, memory traffic and rdata.
  task automatic run_round(input string tag, output bit won_b);
    bit            b_el, win_b, we;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    int            lat, steps;
    if (!a_lock[0]) ref_lock = 1'b0;
    b_el  = b_req[0] && !(ref_lock && a_lock[0]);
    win_b = b_el && (!a_req[0] || !ref_last_b);
    we    = win_b ? b_we[0]    : a_we[0];
    ad    = win_b ? b_addr[0]  : a_addr[0];
    wd    = win_b ? b_wdata[0] : a_wdata[0];
    lat   = we ? 3 : RL0 + 2;
    step();
    check({tag, "_issue_en"},   32'(g_dut[0].mem_en),   32'd1);
    check({tag, "_issue_we"},   32'(g_dut[0].mem_we),   32'(we));
    check({tag, "_issue_addr"}, 32'(g_dut[0].mem_addr), 32'(ad));
    check({tag, "_issue_busy"}, 32'(g_dut[0].busy),     32'd1);
    if (we) check({tag, "_issue_din"}, g_dut[0].mem_din, wd);
    steps = 1;
    while (!(g_dut[0].a_ack || g_dut[0].b_ack) && steps < 16) begin
      step();
      steps++;
      check({tag, "_en_low"}, 32'({g_dut[0].mem_en, g_dut[0].mem_we}), 32'd0);
    end
    check({tag, "_latency"}, 32'(steps), 32'(lat - 1));
    check({tag, "_a_ack"},   32'(g_dut[0].a_ack), 32'(!win_b));
    check({tag, "_b_ack"},   32'(g_dut[0].b_ack), 32'(win_b));
    won_b = g_dut[0].b_ack;
    ref_last_b = win_b;
    if (we) ref_mem[ad] = wd;
    else if (win_b) exp_b_rd = ref_mem[ad];
    else exp_a_rd = ref_mem[ad];
    if (!win_b) ref_lock = a_lock[0];
    check({tag, "_a_rdata"}, g_dut[0].a_rdata, exp_a_rd);
    check({tag, "_b_rdata"}, g_dut[0].b_rdata, exp_b_rd);
    if (win_b) b_req[0] = 1'b0;
    else a_req[0] = 1'b0;
    step();
    check({tag, "_ack_gone"}, 32'({g_dut[0].a_ack, g_dut[0].b_ack}), 32'd0);
    check({tag, "_idle"},     32'(g_dut[0].busy), 32'd0);
  endtask

  // Single A-port transaction on instance 1 or 2; exp is write data or the
  // expected read data.
  task automatic aux_txn(input int k, input bit we, input logic [AW-1:0] ad,
                         input logic [DW-1:0] exp, input int lat, input string tag);
    int            steps;
    bit            ack;
    logic [DW-1:0] rd;
    a_we[k] = we; a_addr[k] = ad; a_wdata[k] = exp; a_req[k] = 1'b1;
    steps = 0;
    ack   = 1'b0;
    while (!ack && steps < 16) begin
      step();
      steps++;
      ack = (k == 1) ? g_dut[1].a_ack : g_dut[2].a_ack;
    end
    rd = (k == 1) ? g_dut[1].a_rdata : g_dut[2].a_rdata;
    check({tag, "_latency"}, 32'(steps), 32'(lat - 1));
    if (!we) check({tag, "_rdata"}, rd, exp);
    a_req[k] = 1'b0;
    step();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      a_req[k] = 1'b0; a_we[k] = 1'b0; a_addr[k] = '0; a_wdata[k] = '0; a_lock[k] = 1'b0;
      b_req[k] = 1'b0; b_we[k] = 1'b0; b_addr[k] = '0; b_wdata[k] = '0;
    end
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(10'(i));
    ref_last_b = 1'b1; ref_lock = 1'b0; exp_a_rd = '0; exp_b_rd = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    step();

    // Single A write
    a_we[0] = 1'b1; a_addr[0] = 10'h002; a_wdata[0] = 32'h0a03_00ff; a_req[0] = 1'b1;
    run_round("a_wr", got_b);
    check("a_wr_port", 32'(got_b), 32'd0);

    // Single B read of the same word
    b_we[0] = 1'b0; b_addr[0] = 10'h002; b_req[0] = 1'b1;
    run_round("b_rd", got_b);
    check("b_rd_port", 32'(got_b), 32'd1);
    check("b_rd_data", g_dut[0].b_rdata, 32'h0a03_00ff);

    // Both ports requesting continuously: grants alternate A, B, A, B
    a_we[0] = 1'b1; a_addr[0] = 10'h010; a_wdata[0] = 32'h1111_0000; a_req[0] = 1'b1;
    b_we[0] = 1'b0; b_addr[0] = 10'h002; b_req[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_round("alt", got_b);
      check("alt_order", 32'(got_b), 32'(i % 2));
      if (got_b) begin
        b_addr[0] = 10'(16 + i); b_req[0] = 1'b1;
      end else begin
        a_addr[0] = 10'(16 + i); a_wdata[0] = 32'h1111_0000 + 32'(i); a_req[0] = 1'b1;
      end
    end

    // A locks across three writes while B keeps requesting
    a_lock[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_round("lock", got_b);
      check("lock_port", 32'(got_b), 32'd0);
      if (i < 2) begin
        a_we[0] = 1'b1; a_addr[0] = 10'(32 + i); a_wdata[0] = 32'h2222_0000 + 32'(i);
        a_req[0] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check("lock_held", 32'({g_dut[0].busy, g_dut[0].b_ack}), 32'd0);
    end
    a_lock[0] = 1'b0;
    run_round("unlock", got_b);
    check("unlock_port", 32'(got_b), 32'd1);

    // Random traffic against the reference model
    for (int r = 0; r < 60; r++) begin
      if (!a_req[0] && ($urandom_range(0, 1) == 1)) begin
        a_we[0] = 1'($urandom_range(0, 1)); a_addr[0] = 10'($urandom_range(0, 15));
        a_wdata[0] = $urandom; a_req[0] = 1'b1;
      end
      if (!b_req[0] && (($urandom_range(0, 1) == 1) || !a_req[0])) begin
        b_we[0] = 1'($urandom_range(0, 1)); b_addr[0] = 10'($urandom_range(0, 15));
        b_wdata[0] = $urandom; b_req[0] = 1'b1;
      end
      a_lock[0] = a_req[0] && ($urandom_range(0, 2) == 0);
      run_round("rnd", got_b);
    end
    a_lock[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (a_req[0] || b_req[0]) run_round("drain", got_b);
    end

    // Reset during WAIT of an A read
    a_we[0] = 1'b0; a_addr[0] = 10'h002; a_req[0] = 1'b1;
    step();
    step();
    check("rst_inflight", 32'(g_dut[0].busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    a_req[0] = 1'b0;
    #2;
    reset_n = 1'b1;
    ref_last_b = 1'b1; ref_lock = 1'b0; exp_a_rd = '0; exp_b_rd = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_no_ack", 32'({g_dut[0].a_ack, g_dut[0].busy}), 32'd0);
    end
    a_we[0] = 1'b1; a_addr[0] = 10'h040; a_wdata[0] = 32'h3333_0001; a_req[0] = 1'b1;
    b_we[0] = 1'b1; b_addr[0] = 10'h041; b_wdata[0] = 32'h3333_0002; b_req[0] = 1'b1;
    run_round("post_rst_tie", got_b);
    check("post_rst_first", 32'(got_b), 32'd0);
    run_round("post_rst_b", got_b);
    check("post_rst_second", 32'(got_b), 32'd1);

    // Extreme read latencies
    aux_txn(1, 1'b1, 10'h005, 32'h1234_5678, 3, "rl1_wr");
    aux_txn(1, 1'b0, 10'h005, 32'h1234_5678, 3, "rl1_rd");
    aux_txn(2, 1'b1, 10'h006, 32'h8765_4321, 3, "rl7_wr");
    aux_txn(2, 1'b0, 10'h006, 32'h8765_4321, 9, "rl7_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/config_memory_arbiter.md
CONFIG_MEMORY_ARBITER -- requirements
Module: config_memory_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, memory word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, memory data width.
REQ-003 The block SHALL have parameter READ_LATENCY, default 2, cycles from mem_en to valid mem_dout; legal range 1..7.
REQ-004 The ports SHALL be as follows. Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- a_req / b_req  in  1  request; held until ack
- a_we / b_we  in  1  1 = write, 0 = read; stable while req
- a_addr / b_addr  in  ADDR_WIDTH  word address; stable while req
- a_wdata / b_wdata  in  DATA_WIDTH  write data; stable while req
- a_lock  in  1  port A exclusive-access request
- a_ack / b_ack  out  1  one-cycle completion pulse
- a_rdata / b_rdata  out  DATA_WIDTH  read data, valid when the matching ack = 1 and we = 0
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_din  out  DATA_WIDTH  memory write data
- mem_dout  in  DATA_WIDTH  memory read data
- busy  out  1  1 when the FSM is not IDLE

Function
REQ-005 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE, and SHALL allow only one transaction in flight.
REQ-006 In IDLE with at least one eligible req, the FSM SHALL register the grant, addr, we and wdata, then go to ISSUE.
REQ-007 In ISSUE, mem_en SHALL be 1 and mem_we SHALL equal the granted we for exactly one cycle, with mem_addr/mem_din driven from the registered command.
REQ-008 A write SHALL go ISSUE->DONE; a read SHALL go ISSUE->WAIT and stay there READ_LATENCY-1 cycles (3-bit counter), then capture mem_dout into the granted rdata register on entry to DONE.
REQ-009 In DONE, only the granted port's ack SHALL be 1, for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-010 Latency from req first sampled in IDLE to ack SHALL be 3 cycles for a write and READ_LATENCY+2 cycles for a read.
REQ-011 req values sampled in ISSUE, WAIT or DONE SHALL be ignored; requesters deassert req on the edge after ack.
REQ-012 Arbitration SHALL be round-robin: if both ports request, the port not granted last wins; a single requester wins immediately.
REQ-013 If a transaction granted to A completes with a_lock = 1, b_req SHALL be ineligible until a_lock is sampled 0 in IDLE; a_lock SHALL be ignored while B is granted.
REQ-014 rdata registers SHALL hold their value until the next read completion on the same port; writes SHALL NOT alter rdata.
REQ-015 mem_we SHALL never be 1 while mem_en = 0; mem_en SHALL be 0 in every state except ISSUE.

Reset
REQ-016 On reset_n = 0, asynchronously: state = IDLE, last-grant = B (A wins the first tie), lock flag cleared, and all outputs (ack, rdata, mem_*, busy) = 0.
REQ-017 Reset asserted mid-transaction SHALL abort it with no ack; after release, the first grant SHALL follow REQ-016 tie rules.

Verification
REQ-018 A write addr 0x002 data 0x0a0300ff, with A and B idle -> mem_en = mem_we = 1 for one cycle with mem_addr 0x002; a_ack appears 3 cycles after req.
REQ-019 B read addr 0x002, READ_LATENCY 2, model returning 0x0a0300ff -> b_ack 4 cycles after req, b_rdata = 0x0a0300ff, a_ack stays 0.
REQ-020 A and B requesting together, back-to-back, continuously -> grants alternate A, B, A, B; each ack is a single cycle.
REQ-021 A holds a_lock = 1 across 3 writes while b_req = 1 -> B is not granted until a_lock = 0 in IDLE, then B is granted next.
REQ-022 reset_n pulsed low during WAIT of an A read -> no a_ack; all outputs 0 immediately; a subsequent tie is granted to A.
REQ-023 READ_LATENCY = 1 and READ_LATENCY = 7 builds -> read ack at 3 and 9 cycles respectively, with correct data.
